// File: rtl/fv_if_fetch_frontend_pkg.sv
// -----------------------------------------------------------------------------
// fv_if_fetch_frontend_pkg
// Shared definitions for the FV instruction-fetch frontend: default widths,
// the fetch FSM state type and the buffered fetch entry record.
// -----------------------------------------------------------------------------
package fv_if_fetch_frontend_pkg;

  localparam int FV_INSTR_WIDTH            = 32;
  localparam int FV_INSTR_ADDR_WIDTH       = 32;
  localparam int FV_IF_MAX_INSTR_PER_CYCLE = 2;
  localparam int FV_IF_FIFO_DEPTH          = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  // Default-width entry; modules with overridden widths build an equivalent
  // locally and hand it to the FIFO as a type parameter.
  typedef struct packed {
    logic [FV_INSTR_WIDTH-1:0]      instr;
    logic [FV_INSTR_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

  // Pointer width that stays legal for a single-entry FIFO.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : fv_if_fetch_frontend_pkg

// File: rtl/fv_if_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fv_if_fetch_fifo
// In-order FIFO accepting up to N entries per cycle (lanes 0..i_wr_cnt-1,
// written in lane order) and releasing at most one per cycle. A flush empties
// it and overrides any same-cycle write or read.
//
// Ports
//   clk, reset_   clock, asynchronous active-low reset
//   i_flush       drop all entries (wins over write and read)
//   i_wr_cnt      number of lanes of i_wr_data to enqueue (0..N)
//   i_wr_data     lane data, lane 0 enqueued first
//   i_rd_en       pop the head entry (ignored when empty)
//   o_rd_data     head entry (only meaningful while o_count != 0)
//   o_count       current number of stored entries
// -----------------------------------------------------------------------------
module fv_if_fetch_fifo
  import fv_if_fetch_frontend_pkg::*;
#(
  parameter int  DEPTH   = FV_IF_FIFO_DEPTH,
  parameter int  N       = FV_IF_MAX_INSTR_PER_CYCLE,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     i_flush,
  input  logic [$clog2(N+1)-1:0]   i_wr_cnt,
  input  entry_t [N-1:0]           i_wr_data,
  input  logic                     i_rd_en,
  output entry_t                   o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = ptr_width(DEPTH);
  localparam int KW = $clog2(N + 1);

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_rd;

  assign w_rd = i_rd_en & (r_count != '0);

  // NOTE: storage has no reset; the count alone defines which slots are live,
  // and the consumer masks the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!i_flush) begin
      for (int i = 0; i < N; i++) begin
        if (KW'(i) < i_wr_cnt) begin
          r_mem[PW'((32'(r_wptr) + 32'(i)) % DEPTH)] <= i_wr_data[i];
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= PW'((32'(r_wptr) + 32'(i_wr_cnt)) % DEPTH);
      if (w_rd) begin
        r_rptr <= PW'((32'(r_rptr) + 32'd1) % DEPTH);
      end
      r_count <= r_count + CW'(i_wr_cnt) - CW'(w_rd);
    end
  end

  assign o_rd_data = r_mem[r_rptr];
  assign o_count   = r_count;

endmodule : fv_if_fetch_fifo

// File: rtl/fv_if_fetch_frontend.sv
// -----------------------------------------------------------------------------
// fv_if_fetch_frontend
// DUT-side instruction-fetch frontend for the FV core fetch interface. Issues
// fetch requests, compacts the granted response lanes into an in-order FIFO
// with generated PCs, and presents one instruction per cycle to EX. Handles
// stall, kill/redirect flushes and flags malformed responses.
//
// Ports
//   clk, reset_                 clock, asynchronous active-low reset
//   fetch_req / fetch_addr      request and byte address of lane 1
//   fetch_grant                 request accepted, response lanes valid now
//   rsp_valid/rsp_instr/rsp_pc  per-lane valid and instruction, PC of lane 1
//   stall                       blocks new requests (dequeue continues)
//   redirect_valid/redirect_pc  kill: flush everything, refetch at new PC
//   out_valid/out_instr/out_pc  head instruction toward EX
//   out_ready                   EX consumes the head this cycle
//   occupancy                   FIFO entry count
//   protocol_err                sticky malformed-response flag
// -----------------------------------------------------------------------------
module fv_if_fetch_frontend
  import fv_if_fetch_frontend_pkg::*;
#(
  parameter int INSTR_WIDTH          = FV_INSTR_WIDTH,
  parameter int ADDR_WIDTH           = FV_INSTR_ADDR_WIDTH,
  parameter int MAX_INSTR_PER_CYCLE  = FV_IF_MAX_INSTR_PER_CYCLE,
  parameter int DEPTH                = FV_IF_FIFO_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                                       clk,
  input  logic                                       reset_,
  output logic                                       fetch_req,
  output logic [ADDR_WIDTH-1:0]                      fetch_addr,
  input  logic                                       fetch_grant,
  input  logic [MAX_INSTR_PER_CYCLE-1:0]             rsp_valid,
  input  logic [MAX_INSTR_PER_CYCLE*INSTR_WIDTH-1:0] rsp_instr,
  input  logic [ADDR_WIDTH-1:0]                      rsp_pc,
  input  logic                                       stall,
  input  logic                                       redirect_valid,
  input  logic [ADDR_WIDTH-1:0]                      redirect_pc,
  output logic                                       out_valid,
  output logic [INSTR_WIDTH-1:0]                     out_instr,
  output logic [ADDR_WIDTH-1:0]                      out_pc,
  input  logic                                       out_ready,
  output logic [$clog2(DEPTH):0]                     occupancy,
  output logic                                       protocol_err
);

  localparam int N  = MAX_INSTR_PER_CYCLE;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int KW = $clog2(N + 1);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
  } lane_entry_t;

  fetch_state_e           r_state;
  fetch_state_e           w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_fetch_addr;
  logic                   r_protocol_err;

  logic                   w_room;
  logic                   w_accept;
  logic                   w_deq;
  logic [KW-1:0]          w_k;
  logic                   w_gap;
  logic                   w_pc_mismatch;
  logic [KW-1:0]          w_wr_cnt;
  lane_entry_t [N-1:0]    w_lanes;
  lane_entry_t            w_head;
  logic [CW-1:0]          w_count;

  // Only request when a full N-lane response is guaranteed to fit, judged on
  // the pre-dequeue count so the FIFO can never be overrun.
  assign w_room    = (CW'(DEPTH) - w_count) >= CW'(N);
  assign fetch_req = (r_state == FETCH) & ~stall & ~redirect_valid & w_room;
  assign w_accept  = fetch_req & fetch_grant;

  // Lane compaction: k counts valid lanes contiguous from lane 1; any valid
  // lane after the first invalid one is a gap and is dropped.
  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned (which would infer a latch).
  always_comb begin
    logic seen_invalid;
    w_k          = '0;
    w_gap        = 1'b0;
    seen_invalid = 1'b0;
    w_lanes      = '0;
    for (int i = 0; i < N; i++) begin
      w_lanes[i].instr = rsp_instr[i*INSTR_WIDTH +: INSTR_WIDTH];
      w_lanes[i].pc    = r_fetch_addr + (ADDR_WIDTH'(i) << 2);
      if (!rsp_valid[i]) begin
        seen_invalid = 1'b1;
      end else if (seen_invalid) begin
        w_gap = 1'b1;
      end else begin
        w_k = KW'(i + 1);
      end
    end
  end

  // PCs always come from fetch_addr; a disagreeing rsp_pc is only flagged.
  assign w_pc_mismatch = (rsp_pc != r_fetch_addr) && (w_k != '0);
  assign w_wr_cnt      = w_accept ? w_k : '0;
  assign w_deq         = out_valid & out_ready;

  fv_if_fetch_fifo #(
    .DEPTH   (DEPTH),
    .N       (N),
    .entry_t (lane_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset_    (reset_),
    .i_flush   (redirect_valid),
    .i_wr_cnt  (w_wr_cnt),
    .i_wr_data (w_lanes),
    .i_rd_en   (w_deq),
    .o_rd_data (w_head),
    .o_count   (w_count)
  );

  // BOOT always lasts exactly one cycle; a redirect there still flushes and
  // retargets fetch_addr, but the FSM proceeds straight to FETCH.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = FETCH;
      FETCH:   w_state_nxt = redirect_valid ? FLUSH : FETCH;
      FLUSH:   w_state_nxt = redirect_valid ? FLUSH : FETCH;
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state        <= BOOT;
      r_fetch_addr   <= RESET_PC;
      r_protocol_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) begin
        r_fetch_addr <= redirect_pc;
      end else if (w_accept) begin
        r_fetch_addr <= r_fetch_addr + (ADDR_WIDTH'(w_k) << 2);
      end
      if (w_accept && (w_gap || w_pc_mismatch)) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

  assign fetch_addr   = r_fetch_addr;
  assign occupancy    = w_count;
  assign out_valid    = (w_count != '0);
  // Head storage is unreset, so mask it to zero while nothing is buffered.
  assign out_instr    = out_valid ? w_head.instr : '0;
  assign out_pc       = out_valid ? w_head.pc    : '0;
  assign protocol_err = r_protocol_err;

endmodule : fv_if_fetch_frontend

// File: tb/tb_fv_if_fetch_frontend.sv
// -----------------------------------------------------------------------------
// tb_fv_if_fetch_frontend
// Self-checking bench: directed scenarios plus a randomized run, all checked
// against a queue-based reference model of the fetch frontend.
// -----------------------------------------------------------------------------
module tb_fv_if_fetch_frontend;

  localparam int N     = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_grant;
  logic [1:0]  rsp_valid;
  logic [63:0] rsp_instr;
  logic [31:0] rsp_pc;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [2:0]  occupancy;
  logic        protocol_err;

  fv_if_fetch_frontend #(
    .INSTR_WIDTH(32), .ADDR_WIDTH(32), .MAX_INSTR_PER_CYCLE(N),
    .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset_(reset_),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_grant(fetch_grant),
    .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_pc(rsp_pc),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .occupancy(occupancy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  int          m_state;      // 0 boot, 1 fetching, 2 flushing
  logic [31:0] m_addr;
  logic        m_err;

  logic        exp_req, exp_valid;
  logic [31:0] exp_pc, exp_instr;
  logic [2:0]  exp_occ;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_state = 0;
    m_addr  = 32'h0;
    m_err   = 1'b0;
  endtask

  task automatic model_comb();
    exp_req   = (m_state == 1) && !stall && !redirect_valid &&
                ((DEPTH - m_q.size()) >= N);
    exp_valid = (m_q.size() != 0);
    exp_pc    = exp_valid ? m_q[0].pc : 32'h0;
    exp_instr = exp_valid ? m_q[0].instr : 32'h0;
    exp_occ   = 3'(m_q.size());
  endtask

  task automatic model_update();
    int   k;
    logic gap;
    ent_t e;
    model_comb();
    if (redirect_valid) begin
      m_q.delete();
      m_addr  = redirect_pc;
      m_state = (m_state == 0) ? 1 : 2;
    end else begin
      if (exp_valid && out_ready) void'(m_q.pop_front());
      if (exp_req && fetch_grant) begin
        k = 0;
        for (int i = 0; i < N; i++) if (rsp_valid[i] && k == i) k = i + 1;
        gap = 1'b0;
        for (int i = 0; i < N; i++) if (rsp_valid[i] && i > k) gap = 1'b1;
        if (gap || (k > 0 && rsp_pc != m_addr)) m_err = 1'b1;
        for (int i = 0; i < k; i++) begin
          e.instr = rsp_instr[32*i +: 32];
          e.pc    = m_addr + 32'(4 * i);
          m_q.push_back(e);
        end
        m_addr = m_addr + 32'(4 * k);
      end
      m_state = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_rsp(input logic [1:0] v);
    rsp_valid = v;
    rsp_pc    = m_addr;
    rsp_instr = {instr_of(m_addr + 32'd4), instr_of(m_addr)};
  endtask

  task automatic drain();
    fetch_grant = 1'b0; stall = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8 && m_q.size() != 0; c++) tick();
    #1;
    n_vec++;
    if (occupancy !== 3'd0) begin
      n_err++; $display("FAIL drain_timeout: occupancy %0d, required 0", occupancy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    n_vec++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %0b want 0", fetch_req); end
    n_vec++; if (fetch_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", fetch_addr); end
    n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
    n_vec++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin n_err++; $display("FAIL rst_out: pc %h instr %h want 0", out_pc, out_instr); end
    n_vec++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %0b want 0", protocol_err); end
    @(posedge clk); @(posedge clk); #1;
    reset_ = 1'b1;
  endtask

  task automatic test_stream();
    fetch_grant = 1'b1; out_ready = 1'b1; drive_rsp(2'b11);
    #1;
    n_vec++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL boot_no_req: got %0b want 0", fetch_req); end
    tick();
    for (int j = 0; j < 12; j++) begin
      drive_rsp(2'b11);
      #1;
      model_comb();
      if (j == 0) begin
        n_vec++;
        if (fetch_req !== 1'b1 || fetch_addr !== 32'h0) begin
          n_err++; $display("FAIL stream_first_req: req %0b addr %h want 1 / 0", fetch_req, fetch_addr);
        end
      end else begin
        n_vec++;
        if (out_valid !== 1'b1 || out_pc !== 32'(4*(j-1)) || out_instr !== instr_of(32'(4*(j-1)))) begin
          n_err++; $display("FAIL stream_out_%0d: valid %0b pc %h instr %h want pc %h", j, out_valid, out_pc, out_instr, 4*(j-1));
        end
      end
      n_vec++;
      if (fetch_req !== exp_req) begin n_err++; $display("FAIL stream_req_%0d: got %0b want %0b", j, fetch_req, exp_req); end
      tick();
    end
    n_vec++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL stream_err: got %0b want 0", protocol_err); end
  endtask

  task automatic test_backpressure();
    drain();
    fetch_grant = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 6 && m_q.size() < 4; c++) begin drive_rsp(2'b11); tick(); end
    out_ready = 1'b1; drive_rsp(2'b11); #1;
    n_vec++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL bp_full_occ: got %0d want 4", occupancy); end
    n_vec++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL bp_full_req: got %0b want 0", fetch_req); end
    tick();
    #1;
    n_vec++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL bp_one_free_occ: got %0d want 3", occupancy); end
    n_vec++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL bp_one_free_req: got %0b want 0", fetch_req); end
    tick();
    out_ready = 1'b0; drive_rsp(2'b11); #1;
    n_vec++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL bp_two_free_occ: got %0d want 2", occupancy); end
    n_vec++; if (fetch_req !== 1'b1) begin n_err++; $display("FAIL bp_two_free_req: got %0b want 1", fetch_req); end
    tick();
  endtask

  task automatic test_redirect();
    fetch_grant = 1'b0; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100; fetch_grant = 1'b1; drive_rsp(2'b11);
    #1;
    n_vec++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL rd_pre_occ: got %0d want 3", occupancy); end
    n_vec++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL rd_req_low: got %0b want 0", fetch_req); end
    tick();
    redirect_valid = 1'b0; #1;
    n_vec++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rd_flushed: occ %0d valid %0b want 0/0", occupancy, out_valid); end
    n_vec++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL rd_flush_req: got %0b want 0", fetch_req); end
    tick();
    drive_rsp(2'b11); #1;
    n_vec++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h100) begin n_err++; $display("FAIL rd_new_req: req %0b addr %h want 1 / 100", fetch_req, fetch_addr); end
    tick();
    fetch_grant = 1'b0; #1;
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== instr_of(32'h100)) begin
      n_err++; $display("FAIL rd_first_out: valid %0b pc %h instr %h want pc 100", out_valid, out_pc, out_instr);
    end
    tick();
  endtask

  task automatic test_wrap();
    drain();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    fetch_grant = 1'b1; out_ready = 1'b0; drive_rsp(2'b11); #1;
    n_vec++; if (fetch_req !== 1'b1 || fetch_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_req: req %0b addr %h want 1 / fffffffc", fetch_req, fetch_addr); end
    tick();
    fetch_grant = 1'b0; out_ready = 1'b1; #1;
    n_vec++; if (out_pc !== 32'hFFFF_FFFC || occupancy !== 3'd2) begin n_err++; $display("FAIL wrap_lane1: pc %h occ %0d want fffffffc / 2", out_pc, occupancy); end
    n_vec++; if (fetch_addr !== 32'h4) begin n_err++; $display("FAIL wrap_next_addr: got %h want 4", fetch_addr); end
    tick();
    #1;
    n_vec++; if (out_pc !== 32'h0 || out_instr !== instr_of(32'h0)) begin n_err++; $display("FAIL wrap_lane2: pc %h instr %h want 0", out_pc, out_instr); end
    tick();
  endtask

  task automatic test_gap_err();
    logic [31:0] a;
    drain();
    fetch_grant = 1'b1; out_ready = 1'b0; drive_rsp(2'b10); a = m_addr; #1;
    n_vec++; if (fetch_req !== 1'b1) begin n_err++; $display("FAIL gap_req: got %0b want 1", fetch_req); end
    tick();
    fetch_grant = 1'b0; #1;
    n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL gap_dropped: occ %0d want 0", occupancy); end
    n_vec++; if (protocol_err !== 1'b1) begin n_err++; $display("FAIL gap_err: got %0b want 1", protocol_err); end
    n_vec++; if (fetch_addr !== a) begin n_err++; $display("FAIL gap_addr_held: got %h want %h", fetch_addr, a); end
    fetch_grant = 1'b1; drive_rsp(2'b11);
    tick();
    fetch_grant = 1'b0; #1;
    n_vec++; if (protocol_err !== 1'b1 || occupancy !== 3'd2) begin n_err++; $display("FAIL gap_sticky: err %0b occ %0d want 1 / 2", protocol_err, occupancy); end
  endtask

  task automatic test_async_reset();
    #1 reset_ = 1'b0;
    #1;
    n_vec++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL arst_fifo: occ %0d valid %0b want 0/0", occupancy, out_valid); end
    n_vec++; if (out_pc !== 32'h0 || out_instr !== 32'h0 || fetch_req !== 1'b0) begin n_err++; $display("FAIL arst_out: pc %h instr %h req %0b want 0", out_pc, out_instr, fetch_req); end
    n_vec++; if (fetch_addr !== 32'h0 || protocol_err !== 1'b0) begin n_err++; $display("FAIL arst_state: addr %h err %0b want 0/0", fetch_addr, protocol_err); end
    model_reset();
    #1 reset_ = 1'b1;
    fetch_grant = 1'b1; out_ready = 1'b1; drive_rsp(2'b11); #1;
    n_vec++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL arst_boot: got %0b want 0", fetch_req); end
    tick();
    drive_rsp(2'b11); #1;
    n_vec++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h0) begin n_err++; $display("FAIL arst_first_req: req %0b addr %h want 1 / 0", fetch_req, fetch_addr); end
    tick();
  endtask

  task automatic test_pc_mismatch();
    logic [31:0] a;
    drain();
    fetch_grant = 1'b1; out_ready = 1'b0; drive_rsp(2'b11); a = m_addr;
    rsp_pc = m_addr + 32'h40; #1;
    n_vec++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL pcm_pre_err: got %0b want 0", protocol_err); end
    tick();
    fetch_grant = 1'b0; #1;
    n_vec++; if (protocol_err !== 1'b1) begin n_err++; $display("FAIL pcm_err: got %0b want 1", protocol_err); end
    n_vec++; if (out_pc !== a || occupancy !== 3'd2 || fetch_addr !== a + 32'd8) begin
      n_err++; $display("FAIL pcm_enqueue: pc %h occ %0d addr %h want %h / 2 / %h", out_pc, occupancy, fetch_addr, a, a + 32'd8);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int c = 0; c < 500; c++) begin
      stall          = ($urandom % 5) == 0;
      redirect_valid = (m_state != 0) && (($urandom % 20) == 0);
      r              = $urandom;
      redirect_pc    = r & 32'hFFFF_FFFC;
      fetch_grant    = ($urandom % 10) < 7;
      rsp_valid      = 2'($urandom);
      rsp_instr      = {$urandom, $urandom};
      r              = $urandom;
      rsp_pc         = (($urandom % 8) == 0) ? r : m_addr;
      out_ready      = ($urandom % 10) < 6;
      #1;
      model_comb();
      n_vec++; if (fetch_req !== exp_req) begin n_err++; $display("FAIL rnd_req @%0d: got %0b want %0b", c, fetch_req, exp_req); end
      n_vec++; if (fetch_addr !== m_addr) begin n_err++; $display("FAIL rnd_addr @%0d: got %h want %h", c, fetch_addr, m_addr); end
      n_vec++; if (out_valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid @%0d: got %0b want %0b", c, out_valid, exp_valid); end
      n_vec++; if (out_pc !== exp_pc) begin n_err++; $display("FAIL rnd_pc @%0d: got %h want %h", c, out_pc, exp_pc); end
      n_vec++; if (out_instr !== exp_instr) begin n_err++; $display("FAIL rnd_instr @%0d: got %h want %h", c, out_instr, exp_instr); end
      n_vec++; if (occupancy !== exp_occ) begin n_err++; $display("FAIL rnd_occ @%0d: got %0d want %0d", c, occupancy, exp_occ); end
      n_vec++; if (protocol_err !== m_err) begin n_err++; $display("FAIL rnd_err @%0d: got %0b want %0b", c, protocol_err, m_err); end
      tick();
    end
  endtask

  initial begin
    reset_ = 1'b0; fetch_grant = 1'b0; rsp_valid = '0; rsp_instr = '0; rsp_pc = '0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_gap_err();
    test_async_reset();
    test_pc_mismatch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_fv_if_fetch_frontend

// File: doc/fv_if_fetch_frontend.md
Name: fv_if_fetch_frontend

Overview:
DUT-side counterpart of the FV core instruction-fetch interface. Issues fetch requests with an address, accepts up to N instructions per granted cycle, and buffers them in a small in-order FIFO. Presents one instruction per cycle, with its PC, to the execute stage. Handles stall, and kill/redirect flushes, so the FV fetch/EX trackers see a well-formed request/valid stream.

Parameters:
INSTR_WIDTH, 32, instruction width in bits
ADDR_WIDTH, 32, instruction address width
MAX_INSTR_PER_CYCLE, 2, lanes per fetch response (N); lane 1 is the lowest address
DEPTH, 4, FIFO entries; must be >= N and a power of 2
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock
reset_  in  1  asynchronous, active-low reset
fetch_req  out  1  request a fetch at fetch_addr
fetch_addr  out  ADDR_WIDTH  byte address of lane 1 of the request
fetch_grant  in  1  FV core accepts the request; response lanes are valid in the same cycle
rsp_valid  in  N  per-lane instruction valid, lanes numbered 1..N
rsp_instr  in  N*INSTR_WIDTH  per-lane instruction
rsp_pc  in  ADDR_WIDTH  PC of lane 1
stall  in  1  suppresses new requests
redirect_valid  in  1  kill: flush all state and redirect fetch
redirect_pc  in  ADDR_WIDTH  new fetch address
out_valid  out  1  head-of-FIFO instruction valid toward EX
out_instr  out  INSTR_WIDTH  head instruction
out_pc  out  ADDR_WIDTH  head PC
out_ready  in  1  EX consumes the head this cycle (low when EX is stalled)
occupancy  out  log2(DEPTH)+1  current number of FIFO entries
protocol_err  out  1  sticky flag for malformed responses

Behaviour:
- Reset (async assert on reset_ low, sync release): state=BOOT, fetch_addr=RESET_PC, fetch_req=0, FIFO empty, occupancy=0, out_valid=0, out_instr=0, out_pc=0, protocol_err=0.
- FSM states BOOT, FETCH, FLUSH.
  - BOOT -> FETCH after exactly one cycle. No request is issued in BOOT.
  - FETCH -> FLUSH on redirect_valid.
  - FLUSH -> FETCH after one cycle, unless redirect_valid is high again, in which case FLUSH is held.
- fetch_req is combinational: (state==FETCH) & !stall & !redirect_valid & (DEPTH - occupancy >= N). Occupancy is the pre-dequeue value.
- Response acceptance occurs on fetch_req & fetch_grant.
  - Lanes 1..k are enqueued in order, where k is the count of contiguous valid lanes starting at lane 1.
  - Lane i gets PC = fetch_addr + 4*(i-1).
  - fetch_addr <= fetch_addr + 4*k, using modulo-2^ADDR_WIDTH wrap.
  - k=0 is legal: nothing is enqueued and fetch_addr is held.
- protocol_err is set (sticky until reset) on an accepted response if either condition holds:
  - a valid lane follows an invalid lane; those lanes are dropped;
  - rsp_pc != fetch_addr with k>0; the response is still enqueued using fetch_addr-based PCs.
- rsp_* are ignored when there is no grant. fetch_grant without fetch_req is ignored.
- Dequeue occurs on out_valid & out_ready. out_valid = (occupancy != 0). out_* show the head entry combinationally from the FIFO storage.
- Enqueue and dequeue may happen in the same cycle: occupancy <= occupancy + k - deq.
- Read/write pointers wrap modulo DEPTH. Full is never overrun because of the request guard.
- Redirect takes priority over everything in the same cycle:
  - FIFO is emptied (occupancy <= 0), so out_valid=0 next cycle;
  - any same-cycle response is discarded, and fetch_req is forced low;
  - a same-cycle dequeue still counts as consumed by EX, but has no FIFO effect beyond the flush;
  - fetch_addr <= redirect_pc.
- stall only blocks new requests. Dequeue continues.
- Latency: a response granted in cycle t is visible at out_* in cycle t+1 if the FIFO was empty.
- Reset mid-operation clears all state immediately (asynchronous).

Decomposition:
- Shared FV package holds:
  - fetch_entry_t {instr, pc};
  - fetch_state_e {BOOT, FETCH, FLUSH};
  - the width constants, reusing FV_INSTR_WIDTH, FV_INSTR_ADDR_WIDTH and FV_IF_MAX_INSTR_PER_CYCLE as parameter defaults.
- One sub-module: fv_if_fetch_fifo, a multi-write (up to N), single-read, flushable FIFO with count output.
- Top level contains the FSM, request guard, lane compaction and PC generation.

Test Plan:
- Reset release, grant always high, both lanes valid, out_ready=1 -> BOOT for 1 cycle, then requests at 0x0, 0x8, 0x10; out_pc sequence 0x0, 0x4, 0x8, ... with no gaps after the first fill; protocol_err=0.
- out_ready=0 with continuous grants -> occupancy reaches 4 (DEPTH), fetch_req drops; after one dequeue occupancy=3 and fetch_req stays low (needs 2 free); after two dequeues fetch_req returns.
- redirect_valid with redirect_pc=0x100 while FIFO holds 3 entries and a grant occurs in the same cycle -> next cycle occupancy=0, out_valid=0; one FLUSH cycle with no request; then fetch_addr=0x100 and first out_pc=0x100.
- rsp_valid lanes = {lane1=0, lane2=1} -> nothing enqueued, protocol_err=1 and remains 1; fetch_addr unchanged.
- Fetch near wrap: fetch_addr=0xFFFFFFFC, two valid lanes -> PCs 0xFFFFFFFC and 0x0; next fetch_addr=0x4.
- Assert reset_ mid-stream with occupancy=2 -> outputs return to their reset values asynchronously; after release the first request is at RESET_PC.
